// File: rtl/stream_dest_router.sv
// Per-source routing stage of the stream crossbar: 2-entry input FIFO, tdest decode
// on the first beat of each packet, one-hot request to the arbiters, grant-gated forwarding.
module stream_dest_router #(
    parameter int unsigned M_DATA_COUNT   = 3,
    parameter int unsigned T_DATA_WIDTH   = 8,
    parameter int unsigned T_DEST_WIDTH   = 2,
    parameter int unsigned DROP_CNT_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_in,
    input  logic                      s_tvalid_i,
    output logic                      s_tready_o,
    input  logic [T_DATA_WIDTH-1:0]   s_tdata_i,
    input  logic                      s_tlast_i,
    input  logic [T_DEST_WIDTH-1:0]   s_tdest_i,
    output logic [M_DATA_COUNT-1:0]   req_o,
    input  logic [M_DATA_COUNT-1:0]   grant_i,
    output logic [M_DATA_COUNT-1:0]   m_tvalid_o,
    input  logic [M_DATA_COUNT-1:0]   m_tready_i,
    output logic [T_DATA_WIDTH-1:0]   m_tdata_o,
    output logic                      m_tlast_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

    // One extra bit so M_DATA_COUNT == 2**T_DEST_WIDTH still compares correctly.
    localparam logic [T_DEST_WIDTH:0] DEST_LIMIT = (T_DEST_WIDTH+1)'(M_DATA_COUNT);

    logic [T_DATA_WIDTH-1:0]   data_q [2];
    logic [T_DEST_WIDTH-1:0]   dest_q [2];
    logic [1:0]                last_q;
    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [1:0]                count_q, count_d;
    logic                      ready_q, ready_d;
    state_t                    state_q, state_d;
    logic [M_DATA_COUNT-1:0]   req_q, req_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic                      push;
    logic                      pop;
    logic                      head_valid;
    logic                      head_last;
    logic [T_DEST_WIDTH-1:0]   head_dest;
    logic [M_DATA_COUNT-1:0]   valid;

    assign push       = s_tvalid_i & ready_q;
    assign head_valid = (count_q != 2'd0);
    assign head_last  = last_q[rd_ptr_q];
    assign head_dest  = dest_q[rd_ptr_q];

    assign s_tready_o = ready_q;
    assign req_o      = req_q;
    assign m_tvalid_o = valid;
    assign m_tdata_o  = head_valid ? data_q[rd_ptr_q] : '0;
    assign m_tlast_o  = head_valid & head_last;
    assign drop_cnt_o = drop_cnt_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            data_q[wr_ptr_q] <= s_tdata_i;
            dest_q[wr_ptr_q] <= s_tdest_i;
            last_q[wr_ptr_q] <= s_tlast_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        ready_d = (count_d != 2'd2);
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        drop_cnt_d = drop_cnt_q;
        valid      = '0;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (head_valid) begin
                    if ({1'b0, head_dest} < DEST_LIMIT) begin
                        state_d = BUSY;
                        for (int unsigned d = 0; d < M_DATA_COUNT; d++) begin
                            req_d[d] = (head_dest == T_DEST_WIDTH'(d));
                        end
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            BUSY: begin
                // req_q holds one-hot(dst) for the whole packet, so it is the output select.
                valid = req_q & grant_i & {M_DATA_COUNT{head_valid}};
                pop   = |(valid & m_tready_i);
                if (pop && head_last) begin
                    state_d = IDLE;
                    req_d   = '0;
                end
            end
            DROP: begin
                pop = head_valid;
                if (head_valid && head_last) begin
                    state_d = IDLE;
                    if (drop_cnt_q != '1) begin
                        drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            ready_q    <= 1'b0;
            state_q    <= IDLE;
            req_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            state_q    <= state_d;
            req_q      <= req_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_stream_dest_router.sv
// Bench for stream_dest_router: packets are modelled as queues of expected beats
// (in send order, tagged with the first-beat destination) plus a saturating drop count.
module tb_stream_dest_router;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [1:0] dest;
    } beat_t;

    typedef struct {
        int unsigned port;
        logic [7:0]  data;
        logic        last;
    } obs_t;

    logic       clk_i = 1'b0;
    logic       rst_in;
    logic       s_tvalid_i;
    logic       s_tready_o;
    logic [7:0] s_tdata_i;
    logic       s_tlast_i;
    logic [1:0] s_tdest_i;
    logic [2:0] req_o;
    logic [2:0] grant_i;
    logic [2:0] gnt_en;
    logic [2:0] m_tvalid_o;
    logic [2:0] m_tready_i;
    logic [7:0] m_tdata_o;
    logic       m_tlast_o;
    logic [7:0] drop_cnt_o;

    assign grant_i = req_o & gnt_en;

    always #5 clk_i = ~clk_i;

    stream_dest_router #(
        .M_DATA_COUNT  (3),
        .T_DATA_WIDTH  (8),
        .T_DEST_WIDTH  (2),
        .DROP_CNT_WIDTH(8)
    ) dut (
        .clk_i     (clk_i),
        .rst_in    (rst_in),
        .s_tvalid_i(s_tvalid_i),
        .s_tready_o(s_tready_o),
        .s_tdata_i (s_tdata_i),
        .s_tlast_i (s_tlast_i),
        .s_tdest_i (s_tdest_i),
        .req_o     (req_o),
        .grant_i   (grant_i),
        .m_tvalid_o(m_tvalid_o),
        .m_tready_i(m_tready_i),
        .m_tdata_o (m_tdata_o),
        .m_tlast_o (m_tlast_o),
        .drop_cnt_o(drop_cnt_o)
    );

    beat_t       tx_q [$];
    obs_t        exp_q [$];
    obs_t        obs_q [$];
    int unsigned model_drops;
    int unsigned in_rate;
    bit          in_hs;
    int unsigned inv_err;
    logic [2:0]  cyc_req;
    logic [2:0]  cyc_valid;
    logic [7:0]  cyc_data;
    int unsigned n_checks;
    int unsigned n_pass;

    // Reference model: beats of a valid packet go to the first beat's destination
    // in order; an out-of-range packet produces nothing but one (saturating) drop.
    task automatic send_pkt(input logic [1:0] dest, input int unsigned len,
                            input logic [7:0] base, input bit rnd);
        for (int unsigned i = 0; i < len; i++) begin
            beat_t b;
            b.data = rnd ? 8'($urandom) : base + 8'(i);
            b.last = (i == len - 1);
            b.dest = (rnd && i != 0) ? 2'($urandom) : dest;
            tx_q.push_back(b);
            if (int'(dest) < 3) exp_q.push_back('{port: int'(dest), data: b.data, last: b.last});
        end
        if (int'(dest) >= 3 && model_drops < 255) model_drops++;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic tick();
        if (in_hs) begin
            s_tvalid_i = 1'b0;
            in_hs      = 1'b0;
        end
        if (!s_tvalid_i && tx_q.size() > 0 && $urandom_range(99) < in_rate) begin
            s_tvalid_i = 1'b1;
            s_tdata_i  = tx_q[0].data;
            s_tlast_i  = tx_q[0].last;
            s_tdest_i  = tx_q[0].dest;
        end
        #1;
        if (s_tvalid_i && s_tready_o) begin
            tx_q.delete(0);
            in_hs = 1'b1;
        end
        cyc_req   = req_o;
        cyc_valid = m_tvalid_o;
        cyc_data  = m_tdata_o;
        for (int d = 0; d < 3; d++) begin
            if (m_tvalid_o[d] && m_tready_i[d])
                obs_q.push_back('{port: d, data: m_tdata_o, last: m_tlast_o});
        end
        if ($countones(m_tvalid_o) > 1 || $countones(req_o) > 1) inv_err++;
        if (m_tvalid_o != 3'b000 && req_o == 3'b000) inv_err++;
        @(negedge clk_i);
    endtask

    task automatic run_until_done(input int unsigned budget, input bit rand_io, output bit ok);
        int unsigned c = 0;
        ok = 1'b0;
        while (c < budget && !ok) begin
            if (rand_io) begin
                m_tready_i = 3'($urandom) | 3'($urandom);
                gnt_en     = 3'($urandom) | 3'($urandom);
            end
            tick();
            c++;
            ok = (tx_q.size() == 0) && (obs_q.size() >= exp_q.size());
        end
        m_tready_i = '1;
        gnt_en     = '1;
        repeat (10) tick();
    endtask

    function automatic int sb_diff();
        if (obs_q.size() != exp_q.size()) return -2;
        foreach (obs_q[i]) begin
            if (obs_q[i].port != exp_q[i].port || obs_q[i].data !== exp_q[i].data ||
                obs_q[i].last !== exp_q[i].last) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if (s_tready_o !== 1'b0) $display("FAIL reset_tready: got %b expected 0", s_tready_o);
        else n_pass++;
        n_checks++;
        if ({req_o, m_tvalid_o, m_tdata_o, m_tlast_o, drop_cnt_o} !== 23'd0)
            $display("FAIL reset_outputs: got req=%b valid=%b data=%h last=%b drop=%0d expected all 0",
                     req_o, m_tvalid_o, m_tdata_o, m_tlast_o, drop_cnt_o);
        else n_pass++;
        rst_in = 1'b1;
        #1;
        n_checks++;
        if (s_tready_o !== 1'b0) $display("FAIL reset_tready_pre_edge: got %b expected 0", s_tready_o);
        else n_pass++;
        @(posedge clk_i);
        #1;
        n_checks++;
        if (s_tready_o !== 1'b1) $display("FAIL reset_tready_post_edge: got %b expected 1", s_tready_o);
        else n_pass++;
        @(negedge clk_i);
    endtask

    task automatic test_single_packet();
        logic [2:0] hist [40];
        int first = -1;
        int n100 = 0;
        int nz = 0;
        int bad = 0;
        int d;
        in_rate = 100; m_tready_i = '1; gnt_en = '1;
        send_pkt(2'd2, 4, 8'hA0, 1'b0);
        for (int c = 0; c < 40; c++) begin
            tick();
            hist[c] = cyc_req;
            if (cyc_req != 3'b000) begin
                nz++;
                if (first < 0) first = c;
            end
            if (cyc_req == 3'b100) n100++;
        end
        n_checks++;
        if (n100 != 4 || nz != 4) $display("FAIL single_req_cycles: got %0d (nonzero %0d) expected 4", n100, nz);
        else n_pass++;
        n_checks++;
        if (first != 2) $display("FAIL single_first_latency: got %0d expected 2", first);
        else n_pass++;
        if (first >= 0 && first <= 35) begin
            for (int c = 0; c < 4; c++) if (hist[first + c] != 3'b100) bad++;
            if (hist[first + 4] != 3'b000) bad++;
        end else bad++;
        n_checks++;
        if (bad != 0) $display("FAIL single_req_window: got %0d bad cycles expected 0", bad);
        else n_pass++;
        d = sb_diff();
        n_checks++;
        if (d != -1) $display("FAIL single_data: got diff %0d (obs %0d exp %0d) expected -1", d, obs_q.size(), exp_q.size());
        else n_pass++;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_grant_stall();
        logic [2:0] hist [8];
        int vcnt = 0;
        int bad = 0;
        int d;
        bit ok;
        in_rate = 100; m_tready_i = '1; gnt_en = '0;
        send_pkt(2'd1, 4, 8'hB0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            tick();
            hist[c] = cyc_req;
            if (cyc_valid != 3'b000) vcnt++;
        end
        for (int c = 2; c < 7; c++) if (hist[c] != 3'b010) bad++;
        n_checks++;
        if (vcnt != 0) $display("FAIL stall_no_valid: got %0d valid cycles expected 0", vcnt);
        else n_pass++;
        n_checks++;
        if (bad != 0) $display("FAIL stall_req_held: got %0d bad cycles expected 0", bad);
        else n_pass++;
        n_checks++;
        if (s_tready_o !== 1'b0) $display("FAIL stall_tready: got %b expected 0", s_tready_o);
        else n_pass++;
        n_checks++;
        if (tx_q.size() != 2) $display("FAIL stall_accepted: got %0d beats left expected 2", tx_q.size());
        else n_pass++;
        gnt_en = '1;
        run_until_done(60, 1'b0, ok);
        n_checks++;
        if (!ok) $display("FAIL stall_timeout: got no completion expected completion");
        else n_pass++;
        d = sb_diff();
        n_checks++;
        if (d != -1) $display("FAIL stall_data: got diff %0d (obs %0d exp %0d) expected -1", d, obs_q.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if (req_o !== 3'b000) $display("FAIL stall_req_release: got %b expected 000", req_o);
        else n_pass++;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_invalid_dest();
        int bad = 0;
        int n001 = 0;
        int d;
        in_rate = 100; m_tready_i = '1; gnt_en = '1;
        send_pkt(2'd3, 3, 8'hC0, 1'b0);
        send_pkt(2'd0, 1, 8'hD0, 1'b0);
        for (int c = 0; c < 30; c++) begin
            tick();
            if ((cyc_req & 3'b110) != 3'b000) bad++;
            if (cyc_req == 3'b001) n001++;
        end
        n_checks++;
        if (bad != 0 || n001 != 1) $display("FAIL invalid_req: got bad=%0d req001=%0d expected 0/1", bad, n001);
        else n_pass++;
        n_checks++;
        if (drop_cnt_o !== 8'(model_drops)) $display("FAIL invalid_drop_cnt: got %0d expected %0d", drop_cnt_o, model_drops);
        else n_pass++;
        d = sb_diff();
        n_checks++;
        if (d != -1) $display("FAIL invalid_data: got diff %0d (obs %0d exp %0d) expected -1", d, obs_q.size(), exp_q.size());
        else n_pass++;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [2:0] hist [20];
        logic [2:0] exp_pat [6];
        int first = -1;
        int d;
        exp_pat = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
        in_rate = 100; m_tready_i = '1; gnt_en = '1;
        send_pkt(2'd0, 1, 8'h10, 1'b0);
        send_pkt(2'd1, 1, 8'h20, 1'b0);
        send_pkt(2'd2, 1, 8'h30, 1'b0);
        for (int c = 0; c < 20; c++) begin
            tick();
            hist[c] = cyc_req;
            if (cyc_req != 3'b000 && first < 0) first = c;
        end
        if (first < 0 || first > 14) first = 0;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (hist[first + k] !== exp_pat[k])
                $display("FAIL b2b_req_%0d: got %b expected %b", k, hist[first + k], exp_pat[k]);
            else n_pass++;
        end
        d = sb_diff();
        n_checks++;
        if (d != -1) $display("FAIL b2b_order: got diff %0d (obs %0d exp %0d) expected -1", d, obs_q.size(), exp_q.size());
        else n_pass++;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic       prev_v = 1'b0;
        logic       prev_r = 1'b0;
        logic [7:0] prev_d = 8'h00;
        int d;
        in_rate = 100; gnt_en = '1;
        send_pkt(2'd0, 8, 8'h50, 1'b0);
        for (int c = 0; c < 40; c++) begin
            m_tready_i = {2'b00, (c % 2 == 0)};
            tick();
            if (prev_v && !prev_r) begin
                n_checks++;
                if ({cyc_valid[0], cyc_data} !== {1'b1, prev_d})
                    $display("FAIL bp_hold: got valid=%b data=%h expected valid=1 data=%h", cyc_valid[0], cyc_data, prev_d);
                else n_pass++;
            end
            prev_v = cyc_valid[0];
            prev_r = m_tready_i[0];
            prev_d = cyc_data;
        end
        m_tready_i = '1;
        d = sb_diff();
        n_checks++;
        if (d != -1) $display("FAIL bp_data: got diff %0d (obs %0d exp %0d) expected -1", d, obs_q.size(), exp_q.size());
        else n_pass++;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        int d;
        bit ok;
        in_rate = 70;
        for (int p = 0; p < 40; p++) send_pkt(2'($urandom_range(3)), $urandom_range(4, 1), 8'h00, 1'b1);
        run_until_done(4000, 1'b1, ok);
        n_checks++;
        if (!ok) $display("FAIL rand_timeout: got no completion expected completion");
        else n_pass++;
        d = sb_diff();
        n_checks++;
        if (d != -1) $display("FAIL rand_data: got diff %0d (obs %0d exp %0d) expected -1", d, obs_q.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if (drop_cnt_o !== 8'(model_drops)) $display("FAIL rand_drop_cnt: got %0d expected %0d", drop_cnt_o, model_drops);
        else n_pass++;
        n_checks++;
        if (inv_err != 0) $display("FAIL rand_invariants: got %0d violations expected 0", inv_err);
        else n_pass++;
        obs_q.delete(); exp_q.delete();
        in_rate = 100;
    endtask

    task automatic test_reset_mid();
        int c = 0;
        int d;
        bit ok;
        in_rate = 100; m_tready_i = '1; gnt_en = '1;
        send_pkt(2'd1, 5, 8'hE0, 1'b0);
        while (obs_q.size() < 2 && c < 30) begin
            tick();
            c++;
        end
        n_checks++;
        if (obs_q.size() != 2) $display("FAIL rstmid_progress: got %0d beats expected 2", obs_q.size());
        else n_pass++;
        #2 rst_in = 1'b0;
        #1;
        n_checks++;
        if ({req_o, m_tvalid_o, m_tdata_o, m_tlast_o, drop_cnt_o, s_tready_o} !== 24'd0)
            $display("FAIL rstmid_outputs: got req=%b valid=%b data=%h last=%b drop=%0d rdy=%b expected all 0",
                     req_o, m_tvalid_o, m_tdata_o, m_tlast_o, drop_cnt_o, s_tready_o);
        else n_pass++;
        tx_q.delete(); exp_q.delete(); obs_q.delete();
        s_tvalid_i = 1'b0; in_hs = 1'b0; model_drops = 0;
        repeat (2) @(negedge clk_i);
        rst_in = 1'b1;
        send_pkt(2'd2, 2, 8'hF0, 1'b0);
        run_until_done(60, 1'b0, ok);
        n_checks++;
        if (!ok) $display("FAIL rstmid_timeout: got no completion expected completion");
        else n_pass++;
        d = sb_diff();
        n_checks++;
        if (d != -1) $display("FAIL rstmid_data: got diff %0d (obs %0d exp %0d) expected -1", d, obs_q.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if (drop_cnt_o !== 8'(model_drops)) $display("FAIL rstmid_drop_cnt: got %0d expected %0d", drop_cnt_o, model_drops);
        else n_pass++;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_drop_saturate();
        bit ok;
        in_rate = 100; m_tready_i = '1; gnt_en = '1;
        for (int i = 0; i < 254; i++) send_pkt(2'd3, 1, 8'h00, 1'b1);
        run_until_done(2000, 1'b0, ok);
        n_checks++;
        if (!ok || drop_cnt_o !== 8'(model_drops))
            $display("FAIL sat_below: got %0d (done=%b) expected %0d", drop_cnt_o, ok, model_drops);
        else n_pass++;
        for (int i = 0; i < 3; i++) send_pkt(2'd3, 1, 8'h00, 1'b1);
        run_until_done(200, 1'b0, ok);
        n_checks++;
        if (!ok || drop_cnt_o !== 8'(model_drops))
            $display("FAIL sat_hold: got %0d (done=%b) expected %0d", drop_cnt_o, ok, model_drops);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; inv_err = 0; model_drops = 0;
        in_hs = 1'b0; in_rate = 100;
        s_tvalid_i = 1'b0; s_tdata_i = 8'h00; s_tlast_i = 1'b0; s_tdest_i = 2'd0;
        m_tready_i = '1; gnt_en = '1;
        test_reset();
        test_single_packet();
        test_grant_stall();
        test_invalid_dest();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_drop_saturate();
        n_checks++;
        if (inv_err != 0) $display("FAIL invariants_total: got %0d violations expected 0", inv_err);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected end before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
